// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: scancodes, operator
// encodings, controller state encoding and key decoding helpers.
package calc_pkg;

  // Released-key scancodes
  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_ADD   = 8'h79;
  localparam logic [7:0] SC_SUB   = 8'h7B;
  localparam logic [7:0] SC_MUL   = 8'h7C;
  localparam logic [7:0] SC_DIV   = 8'h4A;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Operator encodings as presented on the op output
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_NONE = 3'b111;

  typedef enum logic [2:0] {
    S_LEFT  = 3'd0,
    S_OP    = 3'd1,
    S_RIGHT = 3'd2,
    S_READY = 3'd3,
    S_DIV   = 3'd4,
    S_SHOW  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_DIGIT = 3'd1,
    K_OPER  = 3'd2,
    K_ENTER = 3'd3,
    K_ESC   = 3'd4
  } key_kind_t;

  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] digit;
    logic [2:0] op;
  } key_t;

  // Returns {is_digit, value}; value is zero for non-digit codes.
  function automatic logic [4:0] decode_digit(input logic [7:0] sc);
    logic [4:0] r;
    case (sc)
      SC_0:    r = {1'b1, 4'd0};
      SC_1:    r = {1'b1, 4'd1};
      SC_2:    r = {1'b1, 4'd2};
      SC_3:    r = {1'b1, 4'd3};
      SC_4:    r = {1'b1, 4'd4};
      SC_5:    r = {1'b1, 4'd5};
      SC_6:    r = {1'b1, 4'd6};
      SC_7:    r = {1'b1, 4'd7};
      SC_8:    r = {1'b1, 4'd8};
      SC_9:    r = {1'b1, 4'd9};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Classifies a scancode into digit / operator / Enter / Esc / ignored.
  function automatic key_t decode_key(input logic [7:0] sc);
    key_t       k;
    logic [4:0] d;
    d       = decode_digit(sc);
    k.kind  = K_NONE;
    k.digit = d[3:0];
    k.op    = OP_NONE;
    if (d[4]) begin
      k.kind = K_DIGIT;
    end else begin
      case (sc)
        SC_ADD:   begin k.kind = K_OPER; k.op = OP_ADD; end
        SC_SUB:   begin k.kind = K_OPER; k.op = OP_SUB; end
        SC_MUL:   begin k.kind = K_OPER; k.op = OP_MUL; end
        SC_DIV:   begin k.kind = K_OPER; k.op = OP_DIV; end
        SC_ENTER: k.kind = K_ENTER;
        SC_ESC:   k.kind = K_ESC;
        default:  k.kind = K_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/calc_ctrl_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, WIDTH steps.
// done is a one-cycle pulse; quotient holds until the next start.
module div_unit
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             active_q, active_d;
  logic [CW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted;

  // Partial remainder with the next dividend bit shifted in.
  assign shifted = {rem_q, quo_q[WIDTH-1]};

  // Next-state for one restoring step; abort beats start beats stepping.
  always_comb begin
    active_d = active_q;
    step_d   = step_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    done_d   = 1'b0;
    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      step_d   = '0;
      rem_d    = '0;
      quo_d    = dividend;
      dvs_d    = divisor;
    end else if (active_q) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = WIDTH'(shifted - {1'b0, dvs_q});
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      step_d = step_q + CW'(1);
      if (step_q == CW'(WIDTH - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // Divider registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      step_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      step_q   <= step_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      done_q   <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/calc_ctrl.sv
// Keypad calculator controller: collects left operand, operator and right
// operand from key-release strobes and computes a 4-bit result on Enter.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag,
  input  logic [7:0]       scancode,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             div_err,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  key_t               key;
  logic               is_digit, is_oper, is_enter, is_esc;
  logic [2*WIDTH-1:0] product;
  logic               div_start, div_abort, div_done;
  logic [WIDTH-1:0]   div_quotient;

  assign key      = decode_key(scancode);
  assign is_digit = flag && (key.kind == K_DIGIT);
  assign is_oper  = flag && (key.kind == K_OPER);
  assign is_enter = flag && (key.kind == K_ENTER);
  assign is_esc   = flag && (key.kind == K_ESC);
  assign product  = left_q * right_q;

  // Controller next-state; Esc takes precedence in every state.
  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    right_d   = right_q;
    op_d      = op_q;
    result_d  = result_q;
    valid_d   = valid_q;
    err_d     = err_q;
    busy_d    = busy_q;
    div_start = 1'b0;
    div_abort = 1'b0;
    if (is_esc) begin
      state_d   = S_LEFT;
      left_d    = '0;
      right_d   = '0;
      op_d      = OP_NONE;
      result_d  = '0;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      busy_d    = 1'b0;
      div_abort = 1'b1;
    end else begin
      case (state_q)
        S_LEFT: begin
          if (is_digit) begin
            left_d  = key.digit;
            valid_d = 1'b0;
            err_d   = 1'b0;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (is_digit) begin
            left_d  = key.digit;
            valid_d = 1'b0;
            err_d   = 1'b0;
          end else if (is_oper) begin
            op_d    = key.op;
            state_d = S_RIGHT;
          end
        end
        S_RIGHT: begin
          if (is_digit) begin
            right_d = key.digit;
            state_d = S_READY;
          end else if (is_oper) begin
            op_d = key.op;
          end
        end
        S_READY: begin
          if (is_digit) begin
            right_d = key.digit;
          end else if (is_oper) begin
            op_d = key.op;
          end else if (is_enter) begin
            case (op_q)
              OP_ADD: begin
                result_d = left_q + right_q;
                valid_d  = 1'b1;
                state_d  = S_SHOW;
              end
              OP_SUB: begin
                result_d = left_q - right_q;
                valid_d  = 1'b1;
                state_d  = S_SHOW;
              end
              OP_MUL: begin
                result_d = product[WIDTH-1:0];
                valid_d  = 1'b1;
                state_d  = S_SHOW;
              end
              OP_DIV: begin
                if (right_q == '0) begin
                  result_d = '1;
                  err_d    = 1'b1;
                  valid_d  = 1'b1;
                  state_d  = S_SHOW;
                end else begin
                  div_start = 1'b1;
                  busy_d    = 1'b1;
                  state_d   = S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          if (div_done) begin
            result_d = div_quotient;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_SHOW;
          end
        end
        S_SHOW: begin
          if (is_digit) begin
            left_d  = key.digit;
            op_d    = OP_NONE;
            valid_d = 1'b0;
            err_d   = 1'b0;
            state_d = S_OP;
          end
        end
        default: state_d = S_LEFT;
      endcase
    end
  end

  // Controller registers with synchronous reset overriding any key.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LEFT;
      left_q   <= '0;
      right_q  <= '0;
      op_q     <= OP_NONE;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  div_unit #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (left_q),
    .divisor  (right_q),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign left         = left_q;
  assign right        = right_q;
  assign op           = op_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign div_err      = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed key sequences followed by
// random key streams, compared cycle by cycle against a behavioural model.
module tb_calc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flag = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic [3:0] left, right, result;
  logic [2:0] op;
  logic       result_valid, div_err, busy;

  calc_ctrl #(.WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .flag         (flag),
    .scancode     (scancode),
    .left         (left),
    .right        (right),
    .op           (op),
    .result       (result),
    .result_valid (result_valid),
    .div_err      (div_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  // Behavioural model: operands, pending division countdown, display phase.
  logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] op_codes[4]     = '{8'h79, 8'h7B, 8'h7C, 8'h4A};
  localparam logic [7:0] K_ENT = 8'h5A;
  localparam logic [7:0] K_ESC = 8'h76;

  int m_left, m_right, m_op, m_result, m_valid, m_err, m_busy;
  int m_phase;   // 0 need left, 1 have left, 2 have op, 3 have right, 4 dividing, 5 showing
  int m_wait, m_quot;

  function automatic int digit_of(input logic [7:0] sc);
    for (int i = 0; i < 10; i++) if (digit_codes[i] == sc) return i;
    return -1;
  endfunction

  function automatic int op_of(input logic [7:0] sc);
    for (int i = 0; i < 4; i++) if (op_codes[i] == sc) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_left = 0; m_right = 0; m_op = 7; m_result = 0;
    m_valid = 0; m_err = 0; m_busy = 0; m_phase = 0; m_wait = 0;
  endtask

  task automatic model_step(input bit r, input bit f, input logic [7:0] sc);
    int d, o;
    if (r || (f && sc == K_ESC)) begin
      model_clear();
      return;
    end
    if (m_phase == 4) begin
      m_wait--;
      if (m_wait == 0) begin
        m_result = m_quot; m_valid = 1; m_busy = 0; m_phase = 5;
      end
      return;
    end
    if (!f) return;
    d = digit_of(sc);
    o = op_of(sc);
    case (m_phase)
      0: if (d >= 0) begin m_left = d; m_valid = 0; m_err = 0; m_phase = 1; end
      1: if (d >= 0) begin m_left = d; m_valid = 0; m_err = 0; end
         else if (o >= 0) begin m_op = o; m_phase = 2; end
      2: if (d >= 0) begin m_right = d; m_phase = 3; end
         else if (o >= 0) m_op = o;
      3: if (d >= 0) m_right = d;
         else if (o >= 0) m_op = o;
         else if (sc == K_ENT) begin
           if (m_op == 3) begin
             if (m_right == 0) begin
               m_result = 15; m_err = 1; m_valid = 1; m_phase = 5;
             end else begin
               m_quot = m_left / m_right; m_busy = 1; m_wait = 5; m_phase = 4;
             end
           end else begin
             case (m_op)
               0: m_result = (m_left + m_right) % 16;
               1: m_result = (m_left - m_right + 16) % 16;
               default: m_result = (m_left * m_right) % 16;
             endcase
             m_valid = 1; m_phase = 5;
           end
         end
      5: if (d >= 0) begin
           m_left = d; m_op = 7; m_valid = 0; m_err = 0; m_phase = 1;
         end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after.
  task automatic tick(input bit r, input bit f, input logic [7:0] sc);
    reset = r; flag = f; scancode = sc;
    @(posedge clk);
    cycle++;
    model_step(r, f, sc);
    #1;
    check("left",         32'(left),         32'(m_left));
    check("right",        32'(right),        32'(m_right));
    check("op",           32'(op),           32'(m_op));
    check("result",       32'(result),       32'(m_result));
    check("result_valid", 32'(result_valid), 32'(m_valid));
    check("div_err",      32'(div_err),      32'(m_err));
    check("busy",         32'(busy),         32'(m_busy));
    @(negedge clk);
  endtask

  task automatic press(input logic [7:0] sc);
    tick(1'b0, 1'b1, sc);
    tick(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    model_clear();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, digit_codes[5]);   // reset beats a coincident digit
    check("reset_op", 32'(op), 32'd7);
    check("reset_left", 32'(left), 32'd0);

    // 7 + 5 = 0xC
    press(digit_codes[7]); press(op_codes[0]); press(digit_codes[5]);
    tick(1'b0, 1'b1, K_ENT);
    check("add_result", 32'(result), 32'hC);
    check("add_valid", 32'(result_valid), 32'd1);
    tick(1'b0, 1'b0, 8'h00);

    // 3 - 5 = 0xE, then 6 * 3 = 0x2
    press(digit_codes[3]); press(op_codes[1]); press(digit_codes[5]); press(K_ENT);
    check("sub_result", 32'(result), 32'hE);
    press(digit_codes[6]); press(op_codes[2]); press(digit_codes[3]); press(K_ENT);
    check("mul_result", 32'(result), 32'h2);

    // 9 / 2: busy for five cycles, keys during busy ignored
    press(digit_codes[9]); press(op_codes[3]); press(digit_codes[2]);
    tick(1'b0, 1'b1, K_ENT);
    check("div_busy_start", 32'(busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, i <= 2, (i == 1) ? digit_codes[1] : op_codes[0]);
      check("div_busy_hold", 32'(busy), 32'd1);
      check("div_right_hold", 32'(right), 32'd2);
    end
    tick(1'b0, 1'b0, 8'h00);
    check("div_result", 32'(result), 32'd4);
    check("div_valid", 32'(result_valid), 32'd1);
    check("div_busy_end", 32'(busy), 32'd0);

    // 8 / 0 -> error, then digit 4 clears it
    press(digit_codes[8]); press(op_codes[3]); press(digit_codes[0]); press(K_ENT);
    check("dz_result", 32'(result), 32'hF);
    check("dz_err", 32'(div_err), 32'd1);
    check("dz_busy", 32'(busy), 32'd0);
    press(digit_codes[4]);
    check("dz_clear_err", 32'(div_err), 32'd0);
    check("dz_clear_valid", 32'(result_valid), 32'd0);
    check("dz_left", 32'(left), 32'd4);
    check("dz_op", 32'(op), 32'd7);
    press(K_ESC);

    // Corrections: 2,3,+,-,5,6 -> 3 - 6 = 0xD
    press(digit_codes[2]); press(digit_codes[3]); press(op_codes[0]); press(op_codes[1]);
    press(digit_codes[5]); press(digit_codes[6]); press(K_ENT);
    check("corr_left", 32'(left), 32'd3);
    check("corr_op", 32'(op), 32'd1);
    check("corr_right", 32'(right), 32'd6);
    check("corr_result", 32'(result), 32'hD);

    // Abort by Esc, then by reset, at busy cycle 2
    for (int k = 0; k < 2; k++) begin
      press(K_ESC);
      press(digit_codes[9]); press(op_codes[3]); press(digit_codes[3]);
      tick(1'b0, 1'b1, K_ENT);
      tick(k == 1, k == 0, K_ESC);
      check("abort_valid", 32'(result_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_op", 32'(op), 32'd7);
      for (int j = 0; j < 8; j++) tick(1'b0, 1'b0, 8'h00);
      check("abort_no_late", 32'(result_valid), 32'd0);
    end

    // Random key stream
    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if ($urandom_range(0, 299) == 0)
        tick(1'b1, 1'($urandom), 8'($urandom));
      else if (sel < 35)
        tick(1'b0, 1'b1, digit_codes[$urandom_range(0, 9)]);
      else if (sel < 55)
        tick(1'b0, 1'b1, op_codes[$urandom_range(0, 3)]);
      else if (sel < 68)
        tick(1'b0, 1'b1, K_ENT);
      else if (sel < 70)
        tick(1'b0, 1'b1, K_ESC);
      else if (sel < 78)
        tick(1'b0, 1'b1, 8'($urandom));
      else
        tick(1'b0, 1'b0, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits (only 4 supported).
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flag  in  1  one-cycle key-release strobe qualifying scancode.
REQ-005 scancode  in  8  released-key scancode, valid only when flag=1.
REQ-006 left  out  4  binary left operand.
REQ-007 right  out  4  binary right operand.
REQ-008 op  out  3  operator: 000 add, 001 sub, 010 mul, 011 div, 111 none.
REQ-009 result  out  4  registered result.
REQ-010 result_valid  out  1  high while result holds a completed computation.
REQ-011 div_err  out  1  high while result is from a divide-by-zero.
REQ-012 busy  out  1  high while a division is in progress.

Function
REQ-013 Digits SHALL decode as: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9; operators 79=add, 7B=sub, 7C=mul, 4A=div; 5A=Enter; 76=Esc; all other codes ignored with no state change.
REQ-014 FSM states SHALL be S_LEFT, S_OP, S_RIGHT, S_READY, S_DIV, S_SHOW; reset state S_LEFT.
REQ-015 S_LEFT: digit -> load left, go S_OP; other keys ignored.
REQ-016 S_OP: operator -> load op, go S_RIGHT; digit -> overwrite left, stay.
REQ-017 S_RIGHT: digit -> load right, go S_READY; operator -> overwrite op, stay.
REQ-018 S_READY: digit -> overwrite right; operator -> overwrite op; Enter -> execute.
REQ-019 Execute, op add/sub/mul: result = (left+right), (left-right), (left*right) each mod 16, registered on the Enter flag edge; result_valid=1 from the next cycle; go S_SHOW.
REQ-020 Execute, op div, right!=0: on the Enter edge start div_unit, busy=1, go S_DIV.
REQ-021 S_DIV: div_unit performs one restoring step per clock, 4 steps; quotient (floor) registered into result 5 edges after the Enter edge; busy=0 and result_valid=1 from that cycle; go S_SHOW.
REQ-022 Execute, op div, right=0: result=4'hF, div_err=1, result_valid=1 on Enter edge; div_unit not started; busy stays 0; go S_SHOW.
REQ-023 S_DIV: all flags ignored except Esc.
REQ-024 S_SHOW: digit -> clear result_valid and div_err, load left, set op=111, go S_OP; Enter -> no effect; operator -> ignored.
REQ-025 Esc in any state SHALL abort any division, clear left, right, result, result_valid, div_err, busy, set op=111, go S_LEFT on the same edge.
REQ-026 result_valid and div_err SHALL clear when any new left digit is accepted.
REQ-027 Outputs left/right/op SHALL remain stable during S_DIV.

Reset
REQ-028 On reset: left=0, right=0, op=111, result=0, result_valid=0, div_err=0, busy=0, state=S_LEFT, div_unit idle.
REQ-029 reset SHALL override a coincident flag and SHALL abort a division mid-operation with no later result.

Structure
REQ-030 Shared package calc_pkg SHALL hold scancode constants, op encodings, FSM state encoding, and digit-decode function.
REQ-031 Sub-module div_unit SHALL implement the 4-step restoring divider with start/done handshake (done one-cycle pulse, quotient stable when done).

Verification
REQ-032 7,+,5,Enter -> result=0xC, result_valid=1 one cycle after Enter flag, busy never high.
REQ-033 3,-,5,Enter -> result=0xE; 6,*,3,Enter -> result=0x2.
REQ-034 9,/,2,Enter -> busy high 5 cycles, result=4 and result_valid=1 exactly 5 edges after Enter; flags for 1 and + during busy ignored.
REQ-035 8,/,0,Enter -> result=0xF, div_err=1, busy=0; next digit 4 clears div_err/result_valid, left=4, op=111.
REQ-036 Corrections: 2,3,+,-,5,6,Enter -> left=3, op=sub, right=6, result=0xD.
REQ-037 Abort: 9,/,3,Enter then Esc at busy cycle 2 -> all outputs at reset values; repeat with reset instead of Esc -> same, no late result_valid.
